// File: rtl/router_fifo.sv
// router_fifo : per-port output buffer of the 1x3 router.
// 16-entry byte FIFO that tags header bytes at write time and uses the tag
// on read to load a packet-length counter. data_out returns to zero once
// the last byte of a packet (its parity byte) has been delivered.
// Optional build macro: ROUTER_FIFO_STATUS_EN adds fifo_level and a sticky
// overflow_err output; without it neither port nor its logic exists.
module router_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_active
`ifdef ROUTER_FIFO_STATUS_EN
    ,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Data payload storage; contents after reset are irrelevant because the
    // pointers define validity, so this array carries no reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Header tags live in flops so reset can clear them.
    logic [DEPTH-1:0]  r_tag;

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [6:0]        r_count;
    logic [DATA_W-1:0] r_data_out;

    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_tag;
    logic [6:0]        w_hdr_count;

    assign w_wr_idx = r_wr_ptr[ADDR_W-1:0];
    assign w_rd_idx = r_rd_ptr[ADDR_W-1:0];

    // Flags come straight from the registered pointers; the extra MSB
    // distinguishes a full buffer from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    // Both requests are judged against the start-of-cycle flags, so a write
    // into a full buffer is dropped even if a read frees a slot this cycle,
    // and a read from an empty buffer is ignored even if a write lands.
    assign w_wr_acc = write_enb && !w_full;
    assign w_rd_acc = read_enb && !w_empty;

    // Head entry, looked up combinationally so the counter can be loaded
    // in the same cycle the header is delivered.
    assign w_rd_data = r_mem[w_rd_idx];
    assign w_rd_tag  = r_tag[w_rd_idx];

    // Header bits [7:2] hold the payload length; +1 accounts for parity.
    assign w_hdr_count = {1'b0, w_rd_data[7:2]} + 7'd1;

    // Store incoming payload byte at the write index.
    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    // One tag flop per entry, captured alongside the data and flushed by
    // either reset so stale headers can never be re-interpreted.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
            // Capture lfd_state for this entry when it is the write target.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_tag[gi] <= 1'b0;
                end else if (soft_reset) begin
                    r_tag[gi] <= 1'b0;
                end else if (w_wr_acc && (w_wr_idx == ADDR_W'(gi))) begin
                    r_tag[gi] <= lfd_state;
                end
            end
        end
    endgenerate

    // Write pointer advances on every accepted write; wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
        end else if (soft_reset) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Read side: registered data_out, read pointer and packet counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else if (soft_reset) begin
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_data_out <= w_rd_data;
            if (w_rd_tag) begin
                r_count <= w_hdr_count;
            end else if (r_count != 7'd0) begin
                r_count <= r_count - 7'd1;
            end
        end else if (r_count == 7'd0) begin
            // Packet finished (or none in flight): park the bus at zero.
            r_data_out <= '0;
        end
    end

    assign data_out   = r_data_out;
    assign full       = w_full;
    assign empty      = w_empty;
    assign pkt_active = (r_count != 7'd0);

`ifdef ROUTER_FIFO_STATUS_EN
    logic r_overflow;

    // Occupancy straight from the pointer difference; range 0..DEPTH.
    assign fifo_level = r_wr_ptr - r_rd_ptr;

    // Sticky flag: any write attempt against a full buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (soft_reset) begin
            r_overflow <= 1'b0;
        end else if (write_enb && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_err = r_overflow;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo with a queue scoreboard: the stimulus
// process pushes the expected byte whenever it issues an accepted read, and
// a monitor pops and compares data_out one edge later.
module tb_router_fifo;

    logic       clock;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_active;
`ifdef ROUTER_FIFO_STATUS_EN
    logic [4:0] fifo_level;
    logic       overflow_err;
`endif

    router_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_active (pkt_active)
`ifdef ROUTER_FIFO_STATUS_EN
        ,
        .fifo_level   (fifo_level),
        .overflow_err (overflow_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mdl_q [$];   // bytes the bench believes are stored
    logic [7:0] exp_q [$];   // bytes expected on data_out after next edge

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] din);
        logic w_acc;
        logic r_acc;
        @(negedge clock);
        write_enb = we;
        read_enb  = re;
        lfd_state = lfd;
        data_in   = din;
        r_acc = re && (mdl_q.size() > 0);
        w_acc = we && (mdl_q.size() < 16);
        if (r_acc) exp_q.push_back(mdl_q.pop_front());
        if (w_acc) mdl_q.push_back(din);
        @(posedge clock);
        #1;
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
        data_in   = 8'h00;
    endtask

    // Monitor: each accepted read yields one byte on data_out after the edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (data_out !== e) begin
                    n_bad++;
                    $display("FAIL rd_data: got 0x%02h required 0x%02h", data_out, e);
                end else begin
                    $display("rd   data_out=0x%02h", data_out);
                end
            end
        end
    end

    initial begin
        logic [4:0] pk;
        reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        #3;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pkt_active", pkt_active, 0);
        chk("rst_data_out", data_out, 0);
`ifdef ROUTER_FIFO_STATUS_EN
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow_err, 0);
`endif
        @(negedge clock);
        reset = 1'b0;

        // Single packet: header 0x0D -> count 4
        cyc(1, 0, 1, 8'h0D);
        cyc(1, 0, 0, 8'hA1);
        cyc(1, 0, 0, 8'hA2);
        cyc(1, 0, 0, 8'hA3);
        cyc(1, 0, 0, 8'hAD);
        chk("pkt_not_empty", empty, 0);
        pk = 5'b01111;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 8'h00);
            chk($sformatf("pkt_active_%0d", i), pkt_active, pk[i]);
        end
        cyc(0, 1, 0, 8'h00);
        chk("pkt_data_zero", data_out, 0);
        chk("pkt_empty", empty, 1);

        // Full boundary
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(i));
        chk("full_after16", full, 1);
        cyc(1, 0, 0, 8'hFF);
        chk("full_after17", full, 1);
`ifdef ROUTER_FIFO_STATUS_EN
        chk("overflow_set", overflow_err, 1);
        chk("level_16", fifo_level, 16);
`endif
        // Full with read and write: read wins, write dropped
        cyc(1, 1, 0, 8'hEE);
        chk("rw_full_notfull", full, 0);
`ifdef ROUTER_FIFO_STATUS_EN
        chk("rw_full_level", fifo_level, 15);
`endif
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 8'h00);
        chk("full_drained", empty, 1);

        // Empty with read and write: write wins, read ignored
        cyc(0, 0, 0, 8'h00);
        chk("idle_data_zero", data_out, 0);
        cyc(1, 1, 0, 8'h77);
        chk("rw_empty_notempty", empty, 0);
        chk("rw_empty_data_out", data_out, 0);
`ifdef ROUTER_FIFO_STATUS_EN
        chk("rw_empty_level", fifo_level, 1);
`endif
        cyc(0, 1, 0, 8'h00);

        // Wrap-around
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'h30 + i));
        chk("wrap_full", full, 1);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'h00);
        chk("wrap_empty", empty, 1);

        // soft_reset mid-packet
        cyc(1, 0, 1, 8'h0D);
        cyc(1, 0, 0, 8'hA1);
        cyc(1, 0, 0, 8'hA2);
        cyc(1, 0, 0, 8'hA3);
        cyc(1, 0, 0, 8'hAD);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h00);
        chk("sr_pre_active", pkt_active, 1);
        @(negedge clock);
        soft_reset = 1'b1;
        mdl_q.delete();
        @(posedge clock);
        #1;
        soft_reset = 1'b0;
        chk("sr_empty", empty, 1);
        chk("sr_pkt_active", pkt_active, 0);
        chk("sr_data_out", data_out, 0);
        chk("sr_full", full, 0);
`ifdef ROUTER_FIFO_STATUS_EN
        chk("sr_overflow", overflow_err, 0);
        chk("sr_level", fifo_level, 0);
`endif
        // New packet: header 0x05 -> count 2
        cyc(1, 0, 1, 8'h05);
        cyc(1, 0, 0, 8'hB1);
        cyc(1, 0, 0, 8'hB4);
        cyc(0, 1, 0, 8'h00);
        chk("sr_new_active", pkt_active, 1);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        chk("sr_new_done", pkt_active, 0);
        cyc(0, 0, 0, 8'h00);
        chk("sr_new_zero", data_out, 0);

        // Async reset with 5 entries stored and a packet in flight
        cyc(1, 0, 1, 8'h0D);
        for (int i = 1; i < 6; i++) cyc(1, 0, 0, 8'(i));
        cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("hold_data_out", data_out, 8'h0D);
        #2;
        reset = 1'b1;
        mdl_q.delete();
        #1;
        chk("ar_empty", empty, 1);
        chk("ar_full", full, 0);
        chk("ar_data_out", data_out, 0);
        chk("ar_pkt_active", pkt_active, 0);
        @(negedge clock);
        reset = 1'b0;
        cyc(0, 0, 0, 8'h00);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
